// File: rtl/fir_controller_if.sv
// fir_controller_if -- handshake and datapath-control bundle for the FIR controller.
//   data_ready          : new sample available (high 2 cycles per sample)
//   new_coefficient_set : coefficient set ready for loading
//   overflow            : combinational datapath overflow flag
//   modwait             : controller busy
//   err                 : last computation overflowed
//   cnt_up              : one-cycle pulse per completed result
//   clear_coeff         : one-cycle pulse clearing the coefficient-set flag
//   coefficient_num     : index of coefficient being fetched
//   op                  : datapath opcode
//   src1, src2, dest    : register-file indices
// slave  = controller side, master = bus/datapath side.
interface fir_controller_if;
    logic       data_ready;
    logic       new_coefficient_set;
    logic       overflow;
    logic       modwait;
    logic       err;
    logic       cnt_up;
    logic       clear_coeff;
    logic [1:0] coefficient_num;
    logic [2:0] op;
    logic [3:0] src1;
    logic [3:0] src2;
    logic [3:0] dest;

    modport slave (
        input  data_ready, new_coefficient_set, overflow,
        output modwait, err, cnt_up, clear_coeff, coefficient_num,
               op, src1, src2, dest
    );

    modport master (
        output data_ready, new_coefficient_set, overflow,
        input  modwait, err, cnt_up, clear_coeff, coefficient_num,
               op, src1, src2, dest
    );
endinterface

// File: rtl/fir_controller.sv
// fir_controller -- sequences a 4-tap FIR datapath: coefficient loading and
// per-sample shift/multiply/accumulate, with overflow abort.
//   clk   : clock, all state on rising edge
//   n_rst : synchronous active-low reset
//   bus   : fir_controller_if.slave (handshake inputs, opcode/select outputs)
// Registers: R0 acc, R1..R4 samples (R1 newest), R5..R8 coeffs, R9 input, R10 product.
module fir_controller (
    input logic        clk,
    input logic        n_rst,
    fir_controller_if.slave bus
);
    localparam logic [4:0] IDLE   = 5'd0,  EIDLE  = 5'd1,
                           LOAD0  = 5'd2,  LOAD1  = 5'd3,
                           LOAD2  = 5'd4,  LOAD3  = 5'd5,
                           CLEAR  = 5'd6,  STORE  = 5'd7,
                           ZERO   = 5'd8,  SHIFT1 = 5'd9,
                           SHIFT2 = 5'd10, SHIFT3 = 5'd11,
                           SHIFT4 = 5'd12, MUL1   = 5'd13,
                           ADD1   = 5'd14, MUL2   = 5'd15,
                           SUB2   = 5'd16, MUL3   = 5'd17,
                           ADD3   = 5'd18, MUL4   = 5'd19,
                           SUB4   = 5'd20;

    localparam logic [2:0] OP_NOP = 3'd0, OP_COPY = 3'd1, OP_LDS = 3'd2,
                           OP_LDC = 3'd3, OP_ADD  = 3'd4, OP_SUB = 3'd5,
                           OP_MUL = 3'd6;

    logic [4:0] state, next_state;
    logic       dr_q, pending, modwait_q, err_q;
    logic       req, pend_any, abort;

    logic [2:0] op_c;
    logic [3:0] src1_c, src2_c, dest_c;
    logic [1:0] cnum_c;
    logic       clear_c, cnt_up_c;

    assign req      = bus.data_ready & ~dr_q;
    assign pend_any = pending | req;

    always_comb begin
        abort = 1'b0;
        case (state)
            ZERO, ADD1, SUB2, ADD3, SUB4: abort = bus.overflow;
            default:                      abort = 1'b0;
        endcase
    end

    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE, EIDLE: begin
                if (bus.new_coefficient_set) next_state = LOAD0;
                else if (pend_any)           next_state = STORE;
                else                         next_state = state;
            end
            LOAD0:  next_state = LOAD1;
            LOAD1:  next_state = LOAD2;
            LOAD2:  next_state = LOAD3;
            LOAD3:  next_state = CLEAR;
            // A request queued during the load goes straight to STORE; the
            // coefficient flag is still high here, so IDLE rules can't apply.
            CLEAR:  next_state = pend_any ? STORE : IDLE;
            STORE:  next_state = ZERO;
            ZERO:   next_state = abort ? EIDLE : SHIFT1;
            SHIFT1: next_state = SHIFT2;
            SHIFT2: next_state = SHIFT3;
            SHIFT3: next_state = SHIFT4;
            SHIFT4: next_state = MUL1;
            MUL1:   next_state = ADD1;
            ADD1:   next_state = abort ? EIDLE : MUL2;
            MUL2:   next_state = SUB2;
            SUB2:   next_state = abort ? EIDLE : MUL3;
            MUL3:   next_state = ADD3;
            ADD3:   next_state = abort ? EIDLE : MUL4;
            MUL4:   next_state = SUB4;
            SUB4:   next_state = abort ? EIDLE : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state     <= IDLE;
            dr_q      <= 1'b0;
            pending   <= 1'b0;
            modwait_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= next_state;
            dr_q      <= bus.data_ready;
            modwait_q <= (next_state != IDLE) && (next_state != EIDLE);
            if (next_state == STORE) pending <= 1'b0;
            else if (req)            pending <= 1'b1;
            if (abort)                    err_q <= 1'b1;
            else if (next_state == STORE) err_q <= 1'b0;
        end
    end

    always_comb begin
        op_c     = OP_NOP;
        src1_c   = '0;
        src2_c   = '0;
        dest_c   = '0;
        cnum_c   = '0;
        clear_c  = 1'b0;
        cnt_up_c = 1'b0;
        case (state)
            LOAD0:  begin op_c = OP_LDC; cnum_c = 2'd0; dest_c = 4'd5; end
            LOAD1:  begin op_c = OP_LDC; cnum_c = 2'd1; dest_c = 4'd6; end
            LOAD2:  begin op_c = OP_LDC; cnum_c = 2'd2; dest_c = 4'd7; end
            LOAD3:  begin op_c = OP_LDC; cnum_c = 2'd3; dest_c = 4'd8; end
            CLEAR:  clear_c = 1'b1;
            STORE:  begin op_c = OP_LDS; dest_c = 4'd9; end
            ZERO:   op_c = OP_SUB;
            SHIFT1: begin op_c = OP_COPY; src1_c = 4'd3; dest_c = 4'd4; end
            SHIFT2: begin op_c = OP_COPY; src1_c = 4'd2; dest_c = 4'd3; end
            SHIFT3: begin op_c = OP_COPY; src1_c = 4'd1; dest_c = 4'd2; end
            SHIFT4: begin op_c = OP_COPY; src1_c = 4'd9; dest_c = 4'd1; end
            MUL1:   begin op_c = OP_MUL; src1_c = 4'd1; src2_c = 4'd5; dest_c = 4'd10; end
            ADD1:   begin op_c = OP_ADD; src2_c = 4'd10; end
            MUL2:   begin op_c = OP_MUL; src1_c = 4'd2; src2_c = 4'd6; dest_c = 4'd10; end
            SUB2:   begin op_c = OP_SUB; src2_c = 4'd10; end
            MUL3:   begin op_c = OP_MUL; src1_c = 4'd3; src2_c = 4'd7; dest_c = 4'd10; end
            ADD3:   begin op_c = OP_ADD; src2_c = 4'd10; end
            MUL4:   begin op_c = OP_MUL; src1_c = 4'd4; src2_c = 4'd8; dest_c = 4'd10; end
            SUB4:   begin op_c = OP_SUB; src2_c = 4'd10; cnt_up_c = ~bus.overflow; end
            default: op_c = OP_NOP;
        endcase
    end

    assign bus.op              = op_c;
    assign bus.src1            = src1_c;
    assign bus.src2            = src2_c;
    assign bus.dest            = dest_c;
    assign bus.coefficient_num = cnum_c;
    assign bus.clear_coeff     = clear_c;
    assign bus.cnt_up          = cnt_up_c;
    assign bus.modwait         = modwait_q;
    assign bus.err             = err_q;
endmodule

// File: tb/tb_fir_controller.sv
// tb_fir_controller -- directed self-checking bench for fir_controller.
// Output vector packing: {op, src1, src2, dest, coefficient_num,
//                         modwait, err, cnt_up, clear_coeff}
module tb_fir_controller;
    logic clk = 1'b0;
    logic n_rst;
    int   errors = 0;
    int   checks = 0;

    fir_controller_if bus ();

    fir_controller dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] ev(input logic [2:0] op, input logic [3:0] s1,
                                       input logic [3:0] s2, input logic [3:0] d,
                                       input logic [1:0] cn, input logic mw,
                                       input logic er, input logic cu, input logic cc);
        return {op, s1, s2, d, cn, mw, er, cu, cc};
    endfunction

    // Hand-written {op, src1, src2, dest} for sample steps 1 (STORE) .. 14 (SUB4)
    function automatic logic [14:0] step_exp(input int s);
        case (s)
            1:  return {3'd2, 4'd0, 4'd0, 4'd9};
            2:  return {3'd5, 4'd0, 4'd0, 4'd0};
            3:  return {3'd1, 4'd3, 4'd0, 4'd4};
            4:  return {3'd1, 4'd2, 4'd0, 4'd3};
            5:  return {3'd1, 4'd1, 4'd0, 4'd2};
            6:  return {3'd1, 4'd9, 4'd0, 4'd1};
            7:  return {3'd6, 4'd1, 4'd5, 4'd10};
            8:  return {3'd4, 4'd0, 4'd10, 4'd0};
            9:  return {3'd6, 4'd2, 4'd6, 4'd10};
            10: return {3'd5, 4'd0, 4'd10, 4'd0};
            11: return {3'd6, 4'd3, 4'd7, 4'd10};
            12: return {3'd4, 4'd0, 4'd10, 4'd0};
            13: return {3'd6, 4'd4, 4'd8, 4'd10};
            14: return {3'd5, 4'd0, 4'd10, 4'd0};
            default: return '0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [20:0] exp_v);
        logic [20:0] obs;
        obs = {bus.op, bus.src1, bus.src2, bus.dest, bus.coefficient_num,
               bus.modwait, bus.err, bus.cnt_up, bus.clear_coeff};
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Coefficient load from IDLE: LOAD0..3 then CLEAR. Leaves the bench in CLEAR.
    task automatic load_seq(input string tag);
        tick();
        for (int unsigned k = 0; k < 4; k++) begin
            chk($sformatf("%s_load%0d", tag, k),
                ev(3'd3, 4'd0, 4'd0, 4'(5 + k), 2'(k), 1'b1, 1'b0, 1'b0, 1'b0));
            bus.data_ready = 1'b0;
            tick();
        end
        chk({tag, "_clear"}, ev(3'd0, 4'd0, 4'd0, 4'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1));
        bus.new_coefficient_set = 1'b0;
    endtask

    // Walks steps 1..14 of a sample sequence. hold keeps data_ready high in
    // step 1; p1/p2 raise extra 2-cycle data_ready pulses; ovf injects overflow;
    // rst asserts n_rst for one cycle at that step.
    task automatic sample_seq(input string tag, input bit hold, input int ovf,
                              input int p1, input int p2, input int rst);
        logic [14:0] se;
        for (int s = 1; s <= 14; s++) begin
            tick();
            bus.data_ready = (s == 1 && hold) ||
                             (p1 != 0 && (s == p1 || s == p1 + 1)) ||
                             (p2 != 0 && (s == p2 || s == p2 + 1));
            bus.overflow   = (s == ovf);
            #1;
            se = step_exp(s);
            chk($sformatf("%s_s%0d", tag, s),
                {se, 2'd0, 1'b1, 1'b0, (s == 14 && ovf != 14), 1'b0});
            if (s == rst) begin
                n_rst = 1'b0;
                tick();
                n_rst = 1'b1;
                bus.data_ready = 1'b0;
                #1;
                chk({tag, "_after_rst"}, '0);
                return;
            end
            if (s == ovf) begin
                tick();
                bus.overflow   = 1'b0;
                bus.data_ready = 1'b0;
                #1;
                chk({tag, "_eidle"}, ev(3'd0, 4'd0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0));
                return;
            end
        end
    endtask

    initial begin
        n_rst = 1'b0;
        bus.data_ready = 1'b0;
        bus.new_coefficient_set = 1'b0;
        bus.overflow = 1'b0;
        tick();
        tick();
        chk("reset", '0);
        n_rst = 1'b1;
        tick();
        chk("idle0", '0);

        // Coefficient load
        bus.new_coefficient_set = 1'b1;
        #1;
        chk("idle_pre_load", '0);
        load_seq("coef");
        tick();
        chk("coef_idle1", '0);
        tick();
        chk("coef_idle2", '0);

        // Single sample
        bus.data_ready = 1'b1;
        #1;
        chk("single_T", '0);
        sample_seq("single", 1'b1, 0, 0, 0, 0);
        tick();
        bus.data_ready = 1'b0;
        chk("single_done", '0);
        tick();
        chk("single_idle", '0);

        // Overflow in ADD3, then recovery
        bus.data_ready = 1'b1;
        #1;
        sample_seq("ovf", 1'b1, 12, 0, 0, 0);
        tick();
        chk("eidle_hold1", ev(3'd0, 4'd0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        tick();
        chk("eidle_hold2", ev(3'd0, 4'd0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        bus.data_ready = 1'b1;
        #1;
        sample_seq("recover", 1'b1, 0, 0, 0, 0);
        tick();
        chk("recover_idle", '0);

        // Collision: sample edge coincides with coefficient set
        bus.new_coefficient_set = 1'b1;
        bus.data_ready = 1'b1;
        #1;
        chk("coll_T", '0);
        load_seq("coll");
        sample_seq("coll", 1'b0, 0, 0, 0, 0);
        tick();
        chk("coll_idle", '0);

        // Overrun: two edges during one sequence give exactly one more sequence
        bus.data_ready = 1'b1;
        #1;
        sample_seq("ovr_a", 1'b1, 0, 4, 9, 0);
        tick();
        bus.data_ready = 1'b0;
        chk("ovr_gap", '0);
        sample_seq("ovr_b", 1'b0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("ovr_idle%0d", i), '0);
        end

        // Reset at SHIFT2 with a request pending
        bus.data_ready = 1'b1;
        #1;
        sample_seq("rst", 1'b1, 0, 3, 0, 4);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rst_idle%0d", i), '0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fir_controller.md
FIR_CONTROLLER -- requirements
Module: fir_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port n_rst, input, 1 bit: reset, synchronous and active-low; sampled only on the rising edge of clk.
REQ-003 SHALL have port data_ready, input, 1 bit: new sample available from the bus subordinate; held high for 2 cycles per sample.
REQ-004 SHALL have port new_coefficient_set, input, 1 bit: a coefficient set is ready for loading.
REQ-005 SHALL have port overflow, input, 1 bit: datapath overflow flag, combinational, valid in the same cycle as an ADD or SUB op.
REQ-006 SHALL have port modwait, output, 1 bit: controller busy.
REQ-007 SHALL have port err, output, 1 bit: last computation overflowed.
REQ-008 SHALL have port cnt_up, output, 1 bit: one-cycle pulse marking a completed result.
REQ-009 SHALL have port clear_coeff, output, 1 bit: one-cycle pulse that clears the coefficient-set flag.
REQ-010 SHALL have port coefficient_num, output, 2 bits: index of the coefficient being fetched.
REQ-011 SHALL have port op, output, 3 bits: datapath opcode. Encodings: NOP=0, COPY=1, LOAD_SAMPLE=2, LOAD_COEFF=3, ADD=4, SUB=5, MUL=6.
REQ-012 SHALL have ports src1, src2, dest, output, 4 bits each: register-file indices.

Function
REQ-013 Register allocation SHALL be: R0 accumulator; R1..R4 sample history (R1 newest); R5..R8 coefficients F0..F3; R9 incoming sample; R10 product scratch.
REQ-014 A data_ready request SHALL be the rising edge of data_ready, detected against a registered copy of data_ready. The second high cycle SHALL NOT count as a second request.
REQ-015 A request SHALL set a 1-deep pending flag. The flag SHALL clear when STORE is entered. A request arriving while the flag is already set SHALL be dropped.
REQ-016 In IDLE or EIDLE, new_coefficient_set=1 SHALL take priority over a pending sample. Transitions SHALL be: coefficient load to LOAD0; sample to STORE; otherwise stay.
REQ-017 Coefficient load states SHALL be LOAD0..LOAD3, then CLEAR, then IDLE.
- LOADk SHALL drive op=LOAD_COEFF, coefficient_num=k, dest=5+k.
- CLEAR SHALL drive clear_coeff=1 and op=NOP.
REQ-018 Sample sequence, one state per cycle, SHALL be:
- STORE: LOAD_SAMPLE, dest R9.
- ZERO: SUB, R0=R0-R0.
- SHIFT1..SHIFT4: COPY R4<-R3, R3<-R2, R2<-R1, R1<-R9.
- MUL1: R10=R1*R5. ADD1: R0+=R10.
- MUL2: R10=R2*R6. SUB2: R0-=R10.
- MUL3: R10=R3*R7. ADD3: R0+=R10.
- MUL4: R10=R4*R8. SUB4: R0-=R10.
- Then IDLE.
REQ-019 Overflow=1 during ZERO, ADD1, SUB2, ADD3 or SUB4 SHALL abort the sequence to EIDLE and set err=1.
REQ-020 err SHALL stay 1 in EIDLE and SHALL clear on entry to STORE.
REQ-021 cnt_up SHALL be 1 only in the SUB4 cycle, and only when overflow=0.
REQ-022 modwait SHALL be registered, with value 1 exactly when the current state is neither IDLE nor EIDLE.
REQ-023 Unused select fields SHALL be 0. op SHALL be NOP in IDLE and EIDLE.
REQ-024 Latency SHALL be: request edge sampled in cycle T gives STORE at T+1 and SUB4 at T+14, i.e. 14 busy cycles.
REQ-025 A request arriving during LOADk or CLEAR SHALL be serviced directly after the load completes, with no loss.
REQ-026 new_coefficient_set rising mid-sample SHALL be deferred until the sequence returns to IDLE or EIDLE.

Reset
REQ-027 n_rst=0 at a clock edge SHALL force: state IDLE; pending=0; registered data_ready=0; modwait=0; err=0; cnt_up=0; clear_coeff=0; op=NOP; coefficient_num=0; src1=src2=dest=0.
REQ-028 Reset mid-sequence SHALL abandon the sequence with no further ops issued, and no request SHALL be remembered.

Verification
REQ-029 Coefficient load: new_coefficient_set=1 in IDLE -> op=3 for 4 cycles with coefficient_num 0,1,2,3 and dest 5..8, then clear_coeff=1 for exactly 1 cycle, then IDLE. modwait=1 for those 5 cycles.
REQ-030 Single sample: data_ready high for 2 cycles, overflow=0 -> exactly one sequence matching REQ-018, cnt_up at T+14 only, modwait low afterward, err=0.
REQ-031 Overflow: overflow=1 during ADD3 -> next state EIDLE, err=1, no cnt_up. Next data_ready -> err=0 at STORE and a full sequence runs.
REQ-032 Collision: data_ready edge in the same cycle as new_coefficient_set -> the load runs first, then STORE follows immediately after CLEAR.
REQ-033 Overrun: two data_ready edges during one busy sequence -> exactly one additional sequence executes.
REQ-034 Reset at SHIFT2 with n_rst=0 for 1 cycle -> all outputs at their reset values on the next cycle, and the controller stays IDLE without further stimulus.
